pisca_controller: RTL

- Sequencing controller for the 8-LED chaser datapath. Drives the LED shift pattern through a commanded mode for a programmable number of passes, then signals completion.
- Adds start/stop/freeze command handling, an internal step prescaler, per-run mode latching and pass counting.
- Sits between the SWI-derived command bits and the LED output in top.

---
 rtl/pisca_pkg.sv | 34 +++
 rtl/pisca_if.sv | 32 +++
 rtl/pisca_prescaler.sv | 35 +++
 rtl/pisca_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pisca_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pisca_pkg
// Brief    : Shared types and constants for the LED chaser sequencing controller.
// Revision : 1.0
// ============================================================================
package pisca_pkg;

   localparam int NBITS_PISCA = 8;

   localparam logic [NBITS_PISCA-1:0] INICIO_DIR = 8'b1000_0000;
   localparam logic [NBITS_PISCA-1:0] INICIO_ESQ = 8'b0000_0001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      M_RIGHT  = 2'd0,
      M_LEFT   = 2'd1,
      M_BOUNCE = 2'd2,
      M_RSVD   = 2'd3
   } mode_t;

   // The reserved encoding behaves exactly like RIGHT.
   function automatic mode_t decode_mode(input logic [1:0] m);
      return (m == 2'd3) ? M_RIGHT : mode_t'(m);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pisca_if.sv
`default_nettype none
// ============================================================================
// Module   : pisca_if
// Brief    : Command inputs and status outputs of the LED chaser controller.
// Revision : 1.0
// ============================================================================
interface pisca_if #(
   parameter int NBITS_PISCA = 8,
   parameter int NBITS_PASS  = 4
);
   logic                   start;
   logic                   stop;
   logic                   freeze;
   logic [1:0]             mode;
   logic [NBITS_PASS-1:0]  n_passes;
   logic [NBITS_PISCA-1:0] led;
   logic                   busy;
   logic                   done;
   logic [NBITS_PASS-1:0]  pass_cnt;
   logic [1:0]             state;

   modport master (
      output start, stop, freeze, mode, n_passes,
      input  led, busy, done, pass_cnt, state
   );

   modport slave (
      input  start, stop, freeze, mode, n_passes,
      output led, busy, done, pass_cnt, state
   );
endinterface
`default_nettype wire

// File: rtl/pisca_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : pisca_prescaler
// Brief    : Step prescaler; tick on the last count of each TICK_DIV window.
// Revision : 1.0
// ============================================================================
module pisca_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk_2,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int            c_cw   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_cw-1:0] c_last = c_cw'(TICK_DIV - 1);
   localparam logic [c_cw-1:0] c_one  = c_cw'(1);

   logic [c_cw-1:0] r_cnt;

   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_one;
      end
   end

   assign tick = en && !clr && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/pisca_controller.sv
`default_nettype none
// ============================================================================
// Module   : pisca_controller
// Brief    : LED chaser sequencer: start/stop/freeze, mode latching, pass count.
//            Define PISCA_TRAIL_EN to light the previous position as a trail.
// Revision : 1.0
// ============================================================================
module pisca_controller #(
   parameter int NBITS_PISCA = pisca_pkg::NBITS_PISCA,
   parameter int TICK_DIV    = 4,
   parameter int NBITS_PASS  = 4
) (
   input  logic    clk_2,
   input  logic    rst_n,
   pisca_if.slave  bus
);
   import pisca_pkg::*;

   localparam logic [NBITS_PISCA-1:0] c_msb      = {1'b1, {(NBITS_PISCA-1){1'b0}}};
   localparam logic [NBITS_PISCA-1:0] c_lsb      = {{(NBITS_PISCA-1){1'b0}}, 1'b1};
   localparam logic [NBITS_PASS-1:0]  c_pass_one = NBITS_PASS'(1);

   state_t                 r_state;
   mode_t                  r_mode;
   logic                   r_dir_left;
   logic [NBITS_PISCA-1:0] r_pos;
   logic [NBITS_PISCA-1:0] r_led;
   logic                   r_busy;
   logic                   r_done;
   logic [NBITS_PASS-1:0]  r_pass;
   logic [NBITS_PASS-1:0]  r_limit;

   mode_t                  w_mode_in;
   logic [NBITS_PISCA-1:0] w_start_pos;
   logic                   w_tick;
   logic                   w_pre_en;
   logic                   w_pre_clr;
   logic [NBITS_PISCA-1:0] w_pos_nxt;
   logic                   w_dir_nxt;
   logic                   w_end;
   logic                   w_wrap;
   logic [NBITS_PISCA-1:0] w_trail_nxt;
   logic [NBITS_PASS-1:0]  w_pass_nxt;
   logic                   w_hit;

   assign w_mode_in   = decode_mode(bus.mode);
   assign w_start_pos = (w_mode_in == M_LEFT) ? c_lsb : c_msb;

   // HOLD keeps the count; leaving the run (idle, done or stop) clears it.
   assign w_pre_en  = (r_state == RUN) && !bus.stop && !bus.freeze;
   assign w_pre_clr = ((r_state != RUN) && (r_state != HOLD)) || bus.stop;

   pisca_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk_2 (clk_2),
      .rst_n (rst_n),
      .en    (w_pre_en),
      .clr   (w_pre_clr),
      .tick  (w_tick)
   );

   always_comb begin
      w_pos_nxt = r_pos;
      w_dir_nxt = r_dir_left;
      w_end     = 1'b0;
      case (r_mode)
         M_LEFT: begin
            if (r_pos[NBITS_PISCA-1]) begin
               w_pos_nxt = c_lsb;
               w_end     = 1'b1;
            end else begin
               w_pos_nxt = r_pos << 1;
            end
         end
         M_BOUNCE: begin
            // A pass is counted on arriving at an end, where direction turns.
            w_pos_nxt = r_dir_left ? (r_pos << 1) : (r_pos >> 1);
            w_end     = r_dir_left ? w_pos_nxt[NBITS_PISCA-1] : w_pos_nxt[0];
            if (w_end) begin
               w_dir_nxt = ~r_dir_left;
            end
         end
         default: begin
            if (r_pos[0]) begin
               w_pos_nxt = c_msb;
               w_end     = 1'b1;
            end else begin
               w_pos_nxt = r_pos >> 1;
            end
         end
      endcase
   end

   assign w_wrap     = w_end && (r_mode != M_BOUNCE);
   assign w_pass_nxt = r_pass + c_pass_one;
   assign w_hit      = w_end && (r_limit != '0) && (w_pass_nxt == r_limit);

`ifdef PISCA_TRAIL_EN
   assign w_trail_nxt = w_wrap ? '0 : r_pos;
`else
   assign w_trail_nxt = '0;
`endif

   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_mode     <= M_RIGHT;
         r_dir_left <= 1'b0;
         r_pos      <= '0;
         r_led      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= '0;
         r_limit    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start && !bus.stop) begin
                  r_state    <= RUN;
                  r_busy     <= 1'b1;
                  r_mode     <= w_mode_in;
                  r_limit    <= bus.n_passes;
                  r_pass     <= '0;
                  r_dir_left <= 1'b0;
                  r_pos      <= w_start_pos;
                  r_led      <= w_start_pos;
               end
            end
            RUN: begin
               if (bus.stop) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_led   <= '0;
               end else if (bus.freeze) begin
                  r_state <= HOLD;
               end else if (w_tick) begin
                  r_pos      <= w_pos_nxt;
                  r_dir_left <= w_dir_nxt;
                  if (w_end) begin
                     r_pass <= w_pass_nxt;
                  end
                  if (w_hit) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_led   <= '0;
                  end else begin
                     r_led <= w_pos_nxt | w_trail_nxt;
                  end
               end
            end
            HOLD: begin
               if (bus.stop) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_led   <= '0;
               end else if (!bus.freeze) begin
                  r_state <= RUN;
               end
            end
            default: begin
               r_state <= IDLE;
               r_led   <= '0;
            end
         endcase
      end
   end

   assign bus.led      = r_led;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.pass_cnt = r_pass;
   assign bus.state    = r_state;

endmodule
`default_nettype wire
